// File: rtl/mux_4_to_16.sv
// mux_4_to_16: registered 16:1 single-bit selector built as a two-level 4:1 mux tree
//   clk   in   system clock, rising edge
//   rst_n in   asynchronous active-low reset, clears fin
//   inp   in   16-bit data vector, bit i chosen when sel == i
//   sel   in   4-bit select index
//   fin   out  selected bit, registered (1-cycle latency)
module mux_4_to_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] inp,
  input  logic [3:0]  sel,
  output logic        fin
);
  logic [3:0] grp;
  logic       fin_d;
  logic       fin_q;
  for (genvar g = 0; g < 4; g++) begin : g_lvl1
    assign grp[g] = sel[1] ? (sel[0] ? inp[4*g+3] : inp[4*g+2])
                           : (sel[0] ? inp[4*g+1] : inp[4*g]);
  end
  always_comb begin
    fin_d = sel[3] ? (sel[2] ? grp[3] : grp[2]) : (sel[2] ? grp[1] : grp[0]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fin_q <= 1'b0;
    else        fin_q <= fin_d;
  end
  assign fin = fin_q;
endmodule

// File: tb/tb_mux_4_to_16.sv
// tb_mux_4_to_16: directed table-driven bench for the registered 16:1 selector
module tb_mux_4_to_16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] inp = 16'h0;
  logic [3:0]  sel = 4'h0;
  logic        fin;
  int          n_cmp = 0;
  int          n_err = 0;

  typedef struct {
    logic [15:0] inp;
    logic [3:0]  sel;
    logic        exp;
  } vec_t;

  vec_t vecs [12];

  mux_4_to_16 dut (.clk(clk), .rst_n(rst_n), .inp(inp), .sel(sel), .fin(fin));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input logic [15:0] d, input logic [3:0] s);
    inp = d;
    sel = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{16'h789A, 4'hA, 1'b0};
    vecs[1]  = '{16'h789A, 4'h1, 1'b1};
    vecs[2]  = '{16'h789A, 4'h3, 1'b1};
    vecs[3]  = '{16'h789A, 4'h9, 1'b0};
    vecs[4]  = '{16'h789A, 4'h5, 1'b0};
    vecs[5]  = '{16'h789A, 4'hC, 1'b1};
    vecs[6]  = '{16'h5392, 4'hA, 1'b0};
    vecs[7]  = '{16'h5392, 4'h1, 1'b1};
    vecs[8]  = '{16'h5392, 4'h3, 1'b0};
    vecs[9]  = '{16'h5392, 4'h9, 1'b1};
    vecs[10] = '{16'h5392, 4'h5, 1'b0};
    vecs[11] = '{16'h5392, 4'hC, 1'b1};

    inp = 16'hFFFF;
    sel = 4'h0;
    #1;
    chk("reset_async", fin, 1'b0);
    @(posedge clk); #1;
    chk("reset_hold_edge1", fin, 1'b0);
    @(posedge clk); #1;
    chk("reset_hold_edge2", fin, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("reset_release_no_edge", fin, 1'b0);
    @(posedge clk); #1;
    chk("reset_release_first_capture", fin, 1'b1);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].inp, vecs[i].sel);
      chk($sformatf("vec%0d_inp%h_sel%h", i, vecs[i].inp, vecs[i].sel), fin, vecs[i].exp);
    end

    for (int k = 0; k < 16; k++) begin
      for (int s = 0; s < 16; s++) begin
        step(16'h1 << k, 4'(s));
        chk($sformatf("walk_k%0d_sel%0d", k, s), fin, (k == s) ? 1'b1 : 1'b0);
      end
    end

    step(16'h789A, 4'h1);
    chk("midcycle_before", fin, 1'b1);
    sel = 4'hA;
    #2;
    chk("midcycle_hold", fin, 1'b1);
    @(posedge clk); #1;
    chk("midcycle_after_edge", fin, 1'b0);

    step(16'h5392, 4'h9);
    chk("simul_change", fin, 1'b1);

    step(16'h789A, 4'hC);
    chk("async_pre", fin, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_assert_no_edge", fin, 1'b0);
    @(posedge clk); #1;
    chk("async_hold_through_edge", fin, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("async_release_no_edge", fin, 1'b0);
    @(posedge clk); #1;
    chk("async_reacquire", fin, 1'b1);
    step(16'h789A, 4'hA);
    chk("async_resume", fin, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mux_4_to_16.md
Name: mux_4_to_16

Overview:
16-to-1 single-bit selector: a 4-bit select picks one bit of a 16-bit input bus and drives it onto a single output. Built as a two-level tree of 4:1 muxes. The result is registered on the system clock so it can sit directly on a synchronous datapath. Used wherever one flag or status bit must be chosen from a 16-bit vector.

Parameters:
None. Widths are fixed: data 16 bits, select 4 bits.

Ports:
clk    input   1   system clock; all state updates on its rising edge
rst_n  input   1   reset, asynchronous, active-low
inp    input   16  data vector; bit i is the candidate for sel == i
sel    input   4   select index, 0..15, unsigned
fin    output  1   selected bit, registered

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset:
  - While rst_n = 0, fin = 0 immediately, independent of clk.
  - The internal register clears to 0.
  - Deassertion takes effect at the next rising clk edge; the first capture uses inp/sel present at that edge.
- Selection function: sel_bit = inp[sel].
  - sel = 0 selects LSB inp[0]; sel = 15 selects MSB inp[15].
  - All 16 codes are valid; there is no out-of-range case.
- Structure:
  - Level 1: four 4:1 muxes indexed by sel[1:0], over groups inp[3:0], inp[7:4], inp[11:8], inp[15:12].
  - Level 2: one 4:1 mux indexed by sel[3:2], choosing among the four level-1 results.
  - The tree is purely combinational. The implementation must be functionally identical to inp[sel].
- Latency:
  - fin <= sel_bit on every rising clk edge while rst_n = 1.
  - Latency is exactly 1 cycle from the inp/sel sampled at an edge to fin.
  - No enable: fin updates on every edge.
- Timing of changes: changes to inp or sel between edges have no effect on fin until the next edge. fin is glitch-free between edges.
- Simultaneous change: if inp and sel both change before the same edge, fin reflects the new inp indexed by the new sel.
- Reset mid-operation: asserting rst_n forces fin to 0 asynchronously, overriding any pending capture. After release, operation resumes with no residual state.
- No X propagation from reset: after reset, fin is a defined 0.

Test Plan:
1. Reset: hold rst_n = 0 with inp = 16'hFFFF, sel = 4'h0, and pulse clk -> fin stays 0. Release rst_n; after the next edge, fin = 1.
2. inp = 16'h789A, apply sel = A, 1, 3, 9, 5, C with one edge each -> fin one cycle later = 0, 1, 1, 0, 0, 1.
3. inp = 16'h5392, apply sel = A, 1, 3, 9, 5, C -> fin = 0, 1, 0, 1, 0, 1.
4. Walking one: inp = 1<<k for k = 0..15, swept over all 16 sel values -> fin = 1 only when sel == k, otherwise 0. This covers both tree levels and the LSB/MSB ends.
5. Mid-cycle change: change sel from 4'h1 to 4'hA between edges with inp = 16'h789A -> fin holds 1 until the next edge, then becomes 0.
6. Async reset mid-stream: with fin = 1, drop rst_n between edges -> fin = 0 immediately, with no clk edge. Release rst_n -> fin re-acquires inp[sel] at the next edge.
